rf_write_buffer: RTL and testbench

- Writer-side front end for the 32-entry register file's single write port.
- Accepts writeback requests from two producers: the ALU path and the load/memory path.
- Queues the requests in an in-order FIFO and drains one entry per cycle onto the RegWrite/Rd_Addr/Rd_Data port.
- Decouples producers from write-port availability: when both paths complete in the same cycle, neither is lost.

---
 rtl/rf_write_buffer_pkg.sv | 11 +
 rtl/rf_write_buffer_if.sv | 45 ++++
 rtl/rf_write_buffer_fifo.sv | 68 ++++++
 rtl/rf_write_buffer.sv | 85 ++++++++
 tb/tb_rf_write_buffer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/rf_write_buffer_pkg.sv
// Shared constants and the queued write-back entry type for the register-file write buffer.
package rf_wb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int ZERO_REG   = 0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/rf_write_buffer_if.sv
// Producer/RF-port bundle for rf_write_buffer; byp_* exist only with RF_WRITE_BUFFER_BYPASS_EN.
interface rf_write_buffer_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
);
   logic                   alu_valid;
   logic [AW-1:0]          alu_addr;
   logic [DW-1:0]          alu_data;
   logic                   alu_ready;
   logic                   mem_valid;
   logic [AW-1:0]          mem_addr;
   logic [DW-1:0]          mem_data;
   logic                   mem_ready;
   logic                   drain_en;
   logic                   RegWrite;
   logic [AW-1:0]          Rd_Addr;
   logic [DW-1:0]          Rd_Data;
   logic [$clog2(DEPTH):0] count;
   logic                   empty;
   logic                   full;
`ifdef RF_WRITE_BUFFER_BYPASS_EN
   logic [AW-1:0]          byp_addr;
   logic                   byp_hit;
   logic [DW-1:0]          byp_data;
`endif

   modport master (
      output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, drain_en,
`ifdef RF_WRITE_BUFFER_BYPASS_EN
      output byp_addr,
      input  byp_hit, byp_data,
`endif
      input  alu_ready, mem_ready, RegWrite, Rd_Addr, Rd_Data, count, empty, full
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, drain_en,
`ifdef RF_WRITE_BUFFER_BYPASS_EN
      input  byp_addr,
      output byp_hit, byp_data,
`endif
      output alu_ready, mem_ready, RegWrite, Rd_Addr, Rd_Data, count, empty, full
   );
endinterface

// File: rtl/rf_write_buffer_fifo.sv
// wb_fifo: dual-push (a before b), single-pop circular buffer; storage is never reset.
// With RF_WRITE_BUFFER_BYPASS_EN it also exposes the entries in age order (oldest first).
module wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_a_vld,
   input  wb_entry_t       push_a,
   input  logic            push_b_vld,
   input  wb_entry_t       push_b,
   input  logic            pop,
   output logic [CW-1:0]   count,
`ifdef RF_WRITE_BUFFER_BYPASS_EN
   output wb_entry_t       age_entries [DEPTH],
`endif
   output wb_entry_t       head
);
   localparam int PW = $clog2(DEPTH);

   wb_entry_t       mem_q [DEPTH];
   wb_entry_t       mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   b_idx;
   logic [1:0]      n_push;

   always_comb begin
      mem_d    = mem_q;
      n_push   = {1'b0, push_a_vld} + {1'b0, push_b_vld};
      // The second push lands one slot after the first when both arrive together.
      b_idx    = push_a_vld ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
      if (push_a_vld) mem_d[wr_ptr_q] = push_a;
      if (push_b_vld) mem_d[b_idx]    = push_b;
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = pop ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
      count_d  = count_q + CW'(n_push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef RF_WRITE_BUFFER_BYPASS_EN
   always_comb begin
      for (int k = 0; k < DEPTH; k++) age_entries[k] = mem_q[PW'(rd_ptr_q + PW'(k))];
   end
`endif

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/rf_write_buffer.sv
// Register-file write buffer: arbitrates ALU/load write-backs into an in-order FIFO and drains
// one per cycle to the RF port. Optional youngest-match bypass under RF_WRITE_BUFFER_BYPASS_EN.
module rf_write_buffer
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_ADDR_W,
   parameter int DW    = REG_DATA_W
) (
   input logic               clk,
   input logic               rst_n,
   rf_write_buffer_if.slave  wb
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] count;
   logic [CW-1:0] free;
   logic          empty;
   logic          mem_rdy, alu_rdy;
   logic          mem_push, alu_push;
   logic          reg_write;
   wb_entry_t     head;
   wb_entry_t     mem_ent, alu_ent;

   assign empty   = (count == '0);
   assign free    = CW'(DEPTH) - count;
   // Load is the older instruction, so it wins the last free slot.
   assign mem_rdy = (free >= CW'(1));
   assign alu_rdy = (free >= CW'(2)) || ((free >= CW'(1)) && !wb.mem_valid);

   // Writes to $zero complete the handshake but are never queued.
   assign mem_push  = wb.mem_valid && mem_rdy && (wb.mem_addr != AW'(ZERO_REG));
   assign alu_push  = wb.alu_valid && alu_rdy && (wb.alu_addr != AW'(ZERO_REG));
   assign mem_ent   = '{addr: wb.mem_addr, data: wb.mem_data};
   assign alu_ent   = '{addr: wb.alu_addr, data: wb.alu_data};
   assign reg_write = !empty && wb.drain_en;

`ifdef RF_WRITE_BUFFER_BYPASS_EN
   wb_entry_t     age_entries [DEPTH];
   logic          byp_hit;
   logic [DW-1:0] byp_data;
`endif

   wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_a_vld (mem_push),
      .push_a     (mem_ent),
      .push_b_vld (alu_push),
      .push_b     (alu_ent),
      .pop        (reg_write),
      .count      (count),
`ifdef RF_WRITE_BUFFER_BYPASS_EN
      .age_entries(age_entries),
`endif
      .head       (head)
   );

`ifdef RF_WRITE_BUFFER_BYPASS_EN
   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count) && (age_entries[k].addr == wb.byp_addr) &&
             (wb.byp_addr != AW'(ZERO_REG))) begin
            byp_hit  = 1'b1;
            byp_data = age_entries[k].data;
         end
      end
   end

   assign wb.byp_hit  = byp_hit;
   assign wb.byp_data = byp_data;
`endif

   assign wb.mem_ready = mem_rdy;
   assign wb.alu_ready = alu_rdy;
   assign wb.RegWrite  = reg_write;
   assign wb.Rd_Addr   = empty ? '0 : head.addr;
   assign wb.Rd_Data   = empty ? '0 : head.data;
   assign wb.count     = count;
   assign wb.empty     = empty;
   assign wb.full      = (count == CW'(DEPTH));
endmodule

// File: tb/tb_rf_write_buffer.sv
// Randomized bench for rf_write_buffer against a queue-based model of the write-back buffer.
module tb_rf_write_buffer;
   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;
   ent_t q[$];

   logic        exp_ardy, exp_mrdy;
   logic [4:0]  byp_a = '0;

   rf_write_buffer_if #(.DEPTH(DEPTH), .AW(5), .DW(32)) wb ();

   rf_write_buffer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .wb   (wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive after negedge, check against model, then advance the model at posedge.
   task automatic cycle(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic de, input logic do_chk);
      int   free;
      logic exp_we;
      @(negedge clk);
      rst_n        = rst;
      wb.alu_valid = av; wb.alu_addr = aa; wb.alu_data = ad;
      wb.mem_valid = mv; wb.mem_addr = ma; wb.mem_data = md;
      wb.drain_en  = de;
`ifdef RF_WRITE_BUFFER_BYPASS_EN
      wb.byp_addr  = byp_a;
`endif
      #1;
      free     = DEPTH - q.size();
      exp_mrdy = (free >= 1);
      exp_ardy = (free >= 2) || (free >= 1 && !mv);
      exp_we   = (q.size() > 0) && de;
      if (do_chk) begin
         chk("count", 64'(wb.count), 64'(q.size()));
         chk("empty", 64'(wb.empty), 64'(q.size() == 0));
         chk("full", 64'(wb.full), 64'(q.size() == DEPTH));
         chk("mem_ready", 64'(wb.mem_ready), 64'(exp_mrdy));
         chk("alu_ready", 64'(wb.alu_ready), 64'(exp_ardy));
         chk("RegWrite", 64'(wb.RegWrite), 64'(exp_we));
         chk("Rd_Addr", 64'(wb.Rd_Addr), (q.size() > 0) ? 64'(q[0].a) : 64'd0);
         chk("Rd_Data", 64'(wb.Rd_Data), (q.size() > 0) ? 64'(q[0].d) : 64'd0);
`ifdef RF_WRITE_BUFFER_BYPASS_EN
         begin
            logic        h = 1'b0;
            logic [31:0] bd = '0;
            foreach (q[i]) if (byp_a != 0 && q[i].a == byp_a) begin h = 1'b1; bd = q[i].d; end
            chk("byp_hit", 64'(wb.byp_hit), 64'(h));
            chk("byp_data", 64'(wb.byp_data), 64'(bd));
         end
`endif
      end
      @(posedge clk);
      if (!rst) begin
         q.delete();
      end else begin
         if (exp_we) void'(q.pop_front());
         if (mv && exp_mrdy && ma != 0) q.push_back('{a: ma, d: md});
         if (av && exp_ardy && aa != 0) q.push_back('{a: aa, d: ad});
      end
   endtask

   task automatic idle(input logic de);
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, de, 1'b1);
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] d, input logic de);
      cycle(1'b1, 1'b1, a, d, 1'b0, 5'd0, 32'd0, de, 1'b1);
   endtask

   initial begin
      logic        av, mv, de;
      logic [4:0]  aa, ma;
      logic [31:0] ad, md;
      rst_n = 1'b0;
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      idle(1'b0);

      // Single ALU write drains after one cycle.
      alu(5'd5, 32'hDEADBEEF, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Simultaneous load and ALU: load first.
      cycle(1'b1, 1'b1, 5'd8, 32'h22, 1'b1, 5'd7, 32'h11, 1'b1, 1'b1);
      idle(1'b1); idle(1'b1); idle(1'b1);

      // Fill to full, then free one slot and offer both producers.
      for (int i = 1; i <= 4; i++) alu(5'(i), 32'(i * 3), 1'b0);
      cycle(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b1);
      idle(1'b1);
      cycle(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) idle(1'b1);

      // Writes to $zero are accepted but dropped.
      alu(5'd0, 32'hFFFF, 1'b1);
      cycle(1'b1, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 1'b1, 1'b1);
      idle(1'b1);

      // Reset mid-drain discards queued writes.
      for (int i = 0; i < 3; i++) alu(5'(11 + i), 32'(100 + i), 1'b0);
      idle(1'b1);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
      idle(1'b1); idle(1'b1);

      // Youngest matching entry wins the bypass.
      alu(5'd9, 32'hA, 1'b0);
      alu(5'd9, 32'hB, 1'b0);
      byp_a = 5'd9; idle(1'b0);
      byp_a = 5'd0; idle(1'b0);
      for (int i = 0; i < 3; i++) idle(1'b1);

      av = 1'b0; mv = 1'b0; aa = '0; ma = '0; ad = '0; md = '0;
      for (int n = 0; n < 3000; n++) begin
         logic rst;
         if (!av || $urandom_range(0, 9) == 0) begin
            av = $urandom_range(0, 1); aa = 5'($urandom_range(0, 12)); ad = $urandom;
         end
         if (!mv || $urandom_range(0, 9) == 0) begin
            mv = $urandom_range(0, 1); ma = 5'($urandom_range(0, 12)); md = $urandom;
         end
         de    = ($urandom_range(0, 9) < 6);
         rst   = ($urandom_range(0, 199) != 0);
         byp_a = 5'($urandom_range(0, 12));
         cycle(rst, av, aa, ad, mv, ma, md, de, 1'b1);
         if (!rst) begin
            av = 1'b0; mv = 1'b0;
         end else begin
            if (av && exp_ardy) av = 1'b0;
            if (mv && exp_mrdy) mv = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
